// File: rtl/lift_pkg.sv
// Shared floor constants, size defaults and scheduler state encoding for the lift scheduler.
// ST_RECALL exists only when LIFT_SCHED_FIRE_EN is defined.
package lift_pkg;

  localparam int NUM_FLOORS_DEF = 5;
  localparam int FLOOR_W_DEF    = 3;

  localparam logic [FLOOR_W_DEF-1:0] G  = 3'd0;
  localparam logic [FLOOR_W_DEF-1:0] F1 = 3'd1;
  localparam logic [FLOOR_W_DEF-1:0] F2 = 3'd2;
  localparam logic [FLOOR_W_DEF-1:0] F3 = 3'd3;
  localparam logic [FLOOR_W_DEF-1:0] F4 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SERVE_UP   = 2'd1,
    ST_SERVE_DOWN = 2'd2
`ifdef LIFT_SCHED_FIRE_EN
    ,
    ST_RECALL     = 2'd3
`endif
  } sched_state_e;

endpackage

// File: rtl/lift_call_latch.sv
// Outstanding-call register: sets on a call pulse, clears when the door opens at that floor.
// flush empties the register and blocks new calls for the cycle (emergency recall).
module lift_call_latch
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  door_open,
  input  logic                  flush,
  output logic [NUM_FLOORS-1:0] pending
);

  logic [NUM_FLOORS-1:0] clr;
  logic [NUM_FLOORS-1:0] pending_d;
  logic [NUM_FLOORS-1:0] pending_q;

  // An out-of-range floor matches no index, so nothing clears.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      clr[i] = door_open && (current_floor == FLOOR_W'(i));
    end
    pending_d = flush ? '0 : ((pending_q | call_btn) & ~clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/lift_req_sched.sv
// SCAN-order lift request scheduler: picks the next target floor from the outstanding calls.
// Optional emergency recall is compiled in with LIFT_SCHED_FIRE_EN.
//   state         | meaning
//   ST_IDLE       | no call being served, req_floor follows current_floor
//   ST_SERVE_UP   | serving calls at or above the lift, lowest first
//   ST_SERVE_DOWN | serving calls at or below the lift, highest first
//   ST_RECALL     | fire recall: target ground, calls discarded
module lift_req_sched
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  door_open,
  input  logic                  fire_recall,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy,
  output logic                  dir_up
);

  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  sched_state_e          state_q, state_d;
  logic [FLOOR_W-1:0]    req_floor_q, req_floor_d;
  logic                  dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0] pending_q;
  logic [FLOOR_W-1:0]    cur;
  logic                  flush;
  logic                  any_above, any_below, up_found, dn_found;
  logic [FLOOR_W-1:0]    up_tgt, dn_tgt;

`ifdef LIFT_SCHED_FIRE_EN
  assign flush = fire_recall || (state_q == ST_RECALL);
`else
  logic unused_fire_recall;
  assign unused_fire_recall = fire_recall;
  assign flush              = 1'b0;
`endif

  lift_call_latch #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_call_latch (
    .clk           (clk),
    .rst           (rst),
    .call_btn      (call_btn),
    .current_floor (current_floor),
    .door_open     (door_open),
    .flush         (flush),
    .pending       (pending_q)
  );

  // A floor report beyond the shaft is treated as the top floor.
  assign cur = (current_floor > TOP_FLOOR) ? TOP_FLOOR : current_floor;

  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    up_found  = 1'b0;
    dn_found  = 1'b0;
    up_tgt    = cur;
    dn_tgt    = cur;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (FLOOR_W'(i) >= cur)) begin
        up_found = 1'b1;
        up_tgt   = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (FLOOR_W'(i) <= cur)) begin
        dn_found = 1'b1;
        dn_tgt   = FLOOR_W'(i);
      end
      if (pending_q[i] && (FLOOR_W'(i) > cur)) any_above = 1'b1;
      if (pending_q[i] && (FLOOR_W'(i) < cur)) any_below = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_floor_d = req_floor_q;
    if (!door_open) begin
      case (state_q)
        ST_IDLE: begin
          if (any_above) begin
            state_d     = ST_SERVE_UP;
            req_floor_d = up_tgt;
          end else if (any_below) begin
            state_d     = ST_SERVE_DOWN;
            req_floor_d = dn_tgt;
          end else begin
            req_floor_d = cur;
          end
        end
        ST_SERVE_UP: begin
          if (up_found) begin
            req_floor_d = up_tgt;
          end else if (any_below) begin
            state_d     = ST_SERVE_DOWN;
            req_floor_d = dn_tgt;
          end else begin
            state_d     = ST_IDLE;
            req_floor_d = cur;
          end
        end
        ST_SERVE_DOWN: begin
          if (dn_found) begin
            req_floor_d = dn_tgt;
          end else if (any_above) begin
            state_d     = ST_SERVE_UP;
            req_floor_d = up_tgt;
          end else begin
            state_d     = ST_IDLE;
            req_floor_d = cur;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
`ifdef LIFT_SCHED_FIRE_EN
    // Recall overrides the door hold in both directions.
    if (fire_recall) begin
      state_d     = ST_RECALL;
      req_floor_d = '0;
    end else if (state_q == ST_RECALL) begin
      state_d = ST_IDLE;
    end
`endif
    case (state_d)
      ST_SERVE_UP:   dir_up_d = 1'b1;
      ST_SERVE_DOWN: dir_up_d = 1'b0;
`ifdef LIFT_SCHED_FIRE_EN
      ST_RECALL:     dir_up_d = 1'b0;
`endif
      default:       dir_up_d = dir_up_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_floor_q <= '0;
      dir_up_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_floor_q <= req_floor_d;
      dir_up_q    <= dir_up_d;
    end
  end

  assign req_floor = req_floor_q;
  assign pending   = pending_q;
  assign busy      = (state_q != ST_IDLE);
  assign dir_up    = dir_up_q;

endmodule

// File: tb/tb_lift_req_sched.sv
// Directed and random stimulus for lift_req_sched, checked against a floor-list reference model.
// Recall scenarios are exercised when LIFT_SCHED_FIRE_EN is defined.
module tb_lift_req_sched;
  import lift_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] call_btn;
  logic [2:0] current_floor;
  logic       door_open;
  logic       fire_recall;
  logic [2:0] req_floor;
  logic [4:0] pending;
  logic       busy;
  logic       dir_up;

  int checks   = 0;
  int failures = 0;

  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_RECALL = 3;
  int         m_state = M_IDLE;
  logic [4:0] m_pend  = '0;
  int         m_req   = 0;
  bit         m_dir   = 1'b1;

  lift_req_sched dut (
    .clk           (clk),
    .rst           (rst),
    .call_btn      (call_btn),
    .current_floor (current_floor),
    .door_open     (door_open),
    .fire_recall   (fire_recall),
    .req_floor     (req_floor),
    .pending       (pending),
    .busy          (busy),
    .dir_up        (dir_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: pending is a set of floors; the target is picked from the floor list ahead of the car.
  function automatic void model_edge(input logic [4:0] c, input int fl, input bit d, input bit f, input bit r);
    int         eff, lo_ge, hi_le, old_state;
    bit         above, below;
    logic [4:0] np;
    if (r) begin
      m_pend = '0; m_state = M_IDLE; m_req = 0; m_dir = 1'b1;
      return;
    end
    eff = (fl > 4) ? 4 : fl;
    lo_ge = -1; hi_le = -1; above = 1'b0; below = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (m_pend[k]) begin
        if (k >= eff && lo_ge < 0) lo_ge = k;
        if (k <= eff) hi_le = k;
        if (k > eff) above = 1'b1;
        if (k < eff) below = 1'b1;
      end
    end
    np = m_pend | c;
    if (d && fl < 5) np[fl] = 1'b0;
    old_state = m_state;
    if (!d) begin
      if (old_state == M_IDLE) begin
        if (above) begin m_state = M_UP; m_req = lo_ge; end
        else if (below) begin m_state = M_DOWN; m_req = hi_le; end
        else m_req = eff;
      end else if (old_state == M_UP) begin
        if (lo_ge >= 0) m_req = lo_ge;
        else if (below) begin m_state = M_DOWN; m_req = hi_le; end
        else begin m_state = M_IDLE; m_req = eff; end
      end else if (old_state == M_DOWN) begin
        if (hi_le >= 0) m_req = hi_le;
        else if (above) begin m_state = M_UP; m_req = lo_ge; end
        else begin m_state = M_IDLE; m_req = eff; end
      end
    end
`ifdef LIFT_SCHED_FIRE_EN
    if (f) begin
      np = '0; m_state = M_RECALL; m_req = 0;
    end else if (old_state == M_RECALL) begin
      np = '0; m_state = M_IDLE;
    end
`else
    if (f) np = np;
`endif
    if (m_state == M_UP) m_dir = 1'b1;
    else if (m_state == M_DOWN || m_state == M_RECALL) m_dir = 1'b0;
    m_pend = np;
  endfunction

  task automatic step(input logic [4:0] c, input int fl, input bit d, input bit f, input bit r);
    call_btn      = c;
    current_floor = 3'(fl);
    door_open     = d;
    fire_recall   = f;
    rst           = r;
    @(posedge clk);
    model_edge(c, fl, d, f, r);
    #1;
    chk("model_pending", 32'(pending), 32'(m_pend));
    chk("model_req_floor", 32'(req_floor), 32'(m_req));
    chk("model_busy", 32'(busy), 32'(m_state != M_IDLE));
    chk("model_dir_up", 32'(dir_up), 32'(m_dir));
    chk("req_in_range", 32'(req_floor <= 3'd4), 32'd1);
    call_btn = '0;
  endtask

  initial begin
    call_btn = '0; current_floor = '0; door_open = 1'b0; fire_recall = 1'b0; rst = 1'b1;

    // Reset then idle
    step(5'b00000, 0, 0, 0, 1);
    step(5'b00000, 0, 0, 0, 1);
    repeat (3) step(5'b00000, 0, 0, 0, 0);
    chk("rst_req", 32'(req_floor), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dir", 32'(dir_up), 32'd1);

    // Single call to floor 3
    step(5'b01000, int'(G), 0, 0, 0);
    chk("s2_pend", 32'(pending), 32'b01000);
    chk("s2_busy_early", 32'(busy), 32'd0);
    step(5'b00000, int'(G), 0, 0, 0);
    chk("s2_req", 32'(req_floor), 32'd3);
    chk("s2_busy", 32'(busy), 32'd1);
    step(5'b00000, int'(F3), 1, 0, 0);
    chk("s2_clear", 32'(pending), 32'd0);
    step(5'b00000, int'(F3), 0, 0, 0);
    chk("s2_idle", 32'(busy), 32'd0);

    // SCAN ordering on the way up, then reversal
    step(5'b10000, 1, 0, 0, 0);
    step(5'b00000, 1, 0, 0, 0);
    chk("s3_req4", 32'(req_floor), 32'd4);
    step(5'b00101, 1, 0, 0, 0);
    step(5'b00000, 1, 0, 0, 0);
    chk("s3_req2", 32'(req_floor), 32'd2);
    step(5'b00000, 2, 1, 0, 0);
    step(5'b00000, 2, 0, 0, 0);
    chk("s3_req4b", 32'(req_floor), 32'd4);
    step(5'b00000, 4, 1, 0, 0);
    step(5'b00000, 4, 0, 0, 0);
    chk("s3_dir", 32'(dir_up), 32'd0);
    chk("s3_req0", 32'(req_floor), 32'd0);
    step(5'b00000, 0, 1, 0, 0);
    step(5'b00000, 0, 0, 0, 0);
    chk("s3_idle", 32'(busy), 32'd0);

    // Press and clear on the same floor: clear wins
    step(5'b00100, 2, 1, 0, 0);
    chk("s4_clear_wins", 32'(pending[2]), 32'd0);
    step(5'b00000, 2, 0, 0, 0);

    // Door held open at floor 1 while a call to 4 arrives
    step(5'b00010, 0, 0, 0, 0);
    step(5'b00000, 0, 0, 0, 0);
    step(5'b10000, 1, 1, 0, 0);
    chk("s5_hold0", 32'(req_floor), 32'd1);
    for (int k = 1; k < 4; k++) begin
      step(5'b00000, 1, 1, 0, 0);
      chk("s5_hold", 32'(req_floor), 32'd1);
    end
    chk("s5_pend4", 32'(pending[4]), 32'd1);
    step(5'b00000, 1, 0, 0, 0);
    step(5'b00000, 1, 0, 0, 0);
    chk("s5_req4", 32'(req_floor), 32'd4);

    // Out-of-range floor report: nothing clears, treated as top
    step(5'b00000, 7, 1, 0, 0);
    chk("oor_noclear", 32'(pending), 32'b10000);
    step(5'b00000, 7, 0, 0, 0);
    chk("oor_req", 32'(req_floor), 32'd4);
    step(5'b00000, 4, 1, 0, 0);
    step(5'b00000, 4, 0, 0, 0);

    // Reset mid-service drops calls on the same edge
    step(5'b00011, 4, 0, 0, 0);
    step(5'b00000, 4, 0, 0, 0);
    chk("mid_busy", 32'(busy), 32'd1);
    step(5'b10000, 4, 0, 0, 1);
    chk("mid_rst_pend", 32'(pending), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req", 32'(req_floor), 32'd0);
    chk("mid_rst_dir", 32'(dir_up), 32'd1);

    step(5'b11010, 0, 0, 0, 0);
    step(5'b00000, 0, 0, 0, 0);
`ifdef LIFT_SCHED_FIRE_EN
    step(5'b00000, 0, 0, 1, 0);
    chk("fire_pend", 32'(pending), 32'd0);
    chk("fire_req", 32'(req_floor), 32'd0);
    chk("fire_busy", 32'(busy), 32'd1);
    step(5'b11111, 0, 0, 1, 0);
    chk("fire_ignore", 32'(pending), 32'd0);
    step(5'b00100, 0, 0, 0, 0);
    chk("fire_exit", 32'(busy), 32'd0);
    step(5'b00000, 0, 0, 0, 0);
    chk("fire_exit_pend", 32'(pending), 32'd0);
`else
    step(5'b00000, 0, 0, 1, 0);
    chk("nofire_pend", 32'(pending), 32'b11010);
    chk("nofire_req", 32'(req_floor), 32'd1);
`endif

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] c;
      int         fl;
      c  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'b00000;
      fl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      step(c, fl, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lift_req_sched.md
LIFT_REQ_SCHED -- requirements
Module: lift_req_sched

Interface
REQ-001 Parameter NUM_FLOORS, default 5: number of served floors, 0 (ground) to 4.
REQ-002 Parameter FLOOR_W, default 3: width of floor-number buses.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port call_btn, input, NUM_FLOORS: one-cycle call pulse per floor; may be multi-hot.
REQ-007 Port current_floor, input, FLOOR_W: floor reported by the lift controller.
REQ-008 Port door_open, input, 1: the lift controller's door-open indication.
REQ-009 Port fire_recall, input, 1: emergency recall request; ignored unless LIFT_SCHED_FIRE_EN is defined.
REQ-010 Port req_floor, output, FLOOR_W: registered target floor driven to the lift controller.
REQ-011 Port pending, output, NUM_FLOORS: registered outstanding calls.
REQ-012 Port busy, output, 1: high when the state is not IDLE.
REQ-013 Port dir_up, output, 1: current scan direction (1 = up).

Function
REQ-014 pending[i] SHALL load (pending[i] | call_btn[i]) & ~clr[i] each cycle, where clr[i] = door_open && current_floor==i.
REQ-015 When a press and a clear hit the same floor in one cycle, the clear SHALL win and pending[i] SHALL read 0.
REQ-016 If current_floor >= NUM_FLOORS, no bit SHALL clear, and the floor SHALL be treated as the top floor for direction decisions.
REQ-017 The states SHALL be IDLE, SERVE_UP and SERVE_DOWN, plus RECALL when the macro is defined.
REQ-018 IDLE transitions:
- any pending floor above current_floor -> SERVE_UP;
- else any pending floor below -> SERVE_DOWN;
- else stay in IDLE with req_floor = current_floor.
REQ-019 SERVE_UP:
- req_floor SHALL be the lowest pending floor >= current_floor;
- if none exists, go to SERVE_DOWN when any floor below is pending, otherwise to IDLE.
REQ-020 SERVE_DOWN SHALL mirror SERVE_UP: target is the highest pending floor <= current_floor; if none exists, go to SERVE_UP or IDLE.
REQ-021 Direction reversal SHALL occur only when no pending floor remains ahead, which gives SCAN ordering.
REQ-022 dir_up SHALL be 1 in SERVE_UP and 0 in SERVE_DOWN and RECALL, and SHALL hold its previous value in IDLE.
REQ-023 The next state and next req_floor SHALL be computed from the registered pending value. Latency is two edges: the pending bit sets on the first edge after a press, and req_floor and the state update on the following edge.
REQ-024 While door_open=1, req_floor and the state SHALL hold their values; pending SHALL continue to latch new calls.
REQ-025 req_floor SHALL never exceed NUM_FLOORS-1.

Reset
REQ-026 On rst:
- state = IDLE;
- req_floor = 0;
- pending = 0;
- busy = 0;
- dir_up = 1.
REQ-027 A reset asserted mid-service SHALL discard all pending calls on that same edge.

Configuration
REQ-028 Macro LIFT_SCHED_FIRE_EN SHALL control emergency recall.
REQ-029 With LIFT_SCHED_FIRE_EN defined:
- fire_recall=1 forces RECALL on the next edge from any state, with pending cleared and req_floor = 0;
- call_btn is ignored while in RECALL;
- when fire_recall falls, the state returns to IDLE.
REQ-030 Without LIFT_SCHED_FIRE_EN, fire_recall SHALL be unconnected internally and the RECALL state SHALL be absent.

Structure
REQ-031 Shared package lift_pkg SHALL hold:
- floor constants G, F1, F2, F3, F4;
- NUM_FLOORS and FLOOR_W defaults;
- the scheduler state encoding.
REQ-032 The pending register and clear logic SHALL be implemented as sub-module lift_call_latch.
REQ-033 The above/below priority search SHALL remain inside lift_req_sched.

Verification
REQ-034 The bench SHALL cover at least these scenarios:
- Reset then idle with no calls -> req_floor=0, pending=0, busy=0, dir_up=1.
- current_floor=0, pulse call_btn=5'b01000 -> pending=5'b01000 after 1 edge; req_floor=3 and busy=1 after 2 edges; then current_floor=3 with door_open=1 -> pending=0 and state back to IDLE.
- Moving up, current_floor=1, pending={4}; pulse floors 2 and 0 -> req_floor=2; after floor 2 clears -> req_floor=4; after floor 4 clears -> dir_up=0 and req_floor=0.
- current_floor=2, door_open=1, call_btn[2] pulsed -> pending[2] stays 0.
- door_open=1 held 4 cycles at floor 1 with a new call at floor 4 -> req_floor remains 1 throughout; pending[4]=1; req_floor=4 two edges after door_open falls.
- LIFT_SCHED_FIRE_EN defined, pending=5'b11010, fire_recall=1 -> next edge: pending=0, req_floor=0; calls ignored; fire_recall=0 -> state IDLE.
